seq_timing_controller: RTL and testbench

- Parametrised, programmable timing sequencer for the atomic-clock experiment cycle. Successor to the fixed 10-state sequence, which had hard-coded per-state durations.
- Runs N_STATES states in order. Each state has a run-time programmable duration in clock cycles and a programmable output pattern driving the experiment control lines.
- Supports start, abort, a finite or continuous repeat count, and status/event outputs for the host interface and the logging blocks.

---
 rtl/seq_timing_pkg.sv | 43 ++++
 rtl/seq_config_table.sv | 51 +++++
 rtl/seq_timing_controller.sv | 166 ++++++++++++++++
 tb/tb_seq_timing_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_timing_pkg.sv
// Shared types and constants for the programmable experiment timing sequencer.
// Holds the control FSM encoding, default widths and the standard cycle durations.
package seq_timing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_e;

  localparam int DEF_N_STATES = 10;
  localparam int DEF_ST_W     = 4;
  localparam int DEF_CNT_W    = 27;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_REP_W    = 16;

  // Durations of the standard 10-state atomic-clock cycle, in clock cycles.
  function automatic logic [DEF_CNT_W-1:0] std_dur(input int unsigned idx);
    case (idx)
      0:       std_dur = 27'd20000;
      1:       std_dur = 27'd50000;
      2:       std_dur = 27'd60000000;
      3:       std_dur = 27'd250000;
      4:       std_dur = 27'd30000000;
      5:       std_dur = 27'd630000;
      6:       std_dur = 27'd1840000;
      7:       std_dur = 27'd1890000;
      8:       std_dur = 27'd950000;
      9:       std_dur = 27'd1200000;
      default: std_dur = 27'd1;
    endcase
  endfunction

  // Full period of the standard cycle.
  function automatic logic [31:0] std_period();
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < DEF_N_STATES; i++) begin
      sum = sum + {5'd0, std_dur(i)};
    end
    std_period = sum;
  endfunction

endpackage

// File: rtl/seq_config_table.sv
// Per-state configuration register file: duration and output pattern per state.
// Synchronous write with out-of-range addresses dropped, combinational read.
module seq_config_table
  import seq_timing_pkg::*;
#(
  parameter int N_STATES = DEF_N_STATES,
  parameter int ST_W     = DEF_ST_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ST_W-1:0]  waddr,
  input  logic [CNT_W-1:0] wdur,
  input  logic [OUT_W-1:0] wpat,
  input  logic [ST_W-1:0]  raddr,
  output logic [CNT_W-1:0] rdur,
  output logic [OUT_W-1:0] rpat
);

  logic [CNT_W-1:0] dur_mem [N_STATES];
  logic [OUT_W-1:0] pat_mem [N_STATES];
  logic             waddr_ok;
  logic             raddr_ok;

  always_comb begin
    waddr_ok = (int'(waddr) < N_STATES);
    raddr_ok = (int'(raddr) < N_STATES);
    if (raddr_ok) begin
      rdur = dur_mem[raddr];
      rpat = pat_mem[raddr];
    end else begin
      rdur = CNT_W'(1);
      rpat = {OUT_W{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STATES; i++) begin
        dur_mem[i] <= CNT_W'(1);
        pat_mem[i] <= {OUT_W{1'b0}};
      end
    end else if (we && waddr_ok) begin
      dur_mem[waddr] <= wdur;
      pat_mem[waddr] <= wpat;
    end
  end

endmodule

// File: rtl/seq_timing_controller.sv
// Programmable timing sequencer: walks N_STATES states with per-state durations
// and output patterns, with start/abort and finite or continuous repetition.
module seq_timing_controller
  import seq_timing_pkg::*;
#(
  parameter int               N_STATES = DEF_N_STATES,
  parameter int               ST_W     = DEF_ST_W,
  parameter int               CNT_W    = DEF_CNT_W,
  parameter int               OUT_W    = DEF_OUT_W,
  parameter int               REP_W    = DEF_REP_W,
  parameter logic [OUT_W-1:0] IDLE_PAT = {OUT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ST_W-1:0]  cfg_addr,
  input  logic [CNT_W-1:0] cfg_dur,
  input  logic [OUT_W-1:0] cfg_pat,
  input  logic             start,
  input  logic             abort,
  input  logic [REP_W-1:0] n_reps,
  output logic             busy,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] n_clks,
  output logic [OUT_W-1:0] pat_out,
  output logic             state_entry,
  output logic [REP_W-1:0] rep_cnt,
  output logic             seq_done
);

  localparam logic [ST_W-1:0] LAST_ST = ST_W'(N_STATES - 1);

  ctrl_e            ctrl;
  logic [ST_W-1:0]  next_idx;
  logic [ST_W-1:0]  rd_addr;
  logic [CNT_W-1:0] rd_dur;
  logic [CNT_W-1:0] rd_last;
  logic [OUT_W-1:0] rd_pat;
  logic [CNT_W-1:0] cur_last;
  logic [REP_W-1:0] reps_lat;
  logic [REP_W-1:0] rep_inc;
  logic             at_last_state;
  logic             at_last_cycle;
  logic             run_complete;

  seq_config_table #(
    .N_STATES (N_STATES),
    .ST_W     (ST_W),
    .CNT_W    (CNT_W),
    .OUT_W    (OUT_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdur  (cfg_dur),
    .wpat  (cfg_pat),
    .raddr (rd_addr),
    .rdur  (rd_dur),
    .rpat  (rd_pat)
  );

  // The table is read at the index about to be entered, so the entry edge
  // latches its duration and pattern without a bubble cycle.
  always_comb begin
    at_last_state = (state == LAST_ST);
    if (at_last_state) begin
      next_idx = ST_W'(0);
    end else begin
      next_idx = state + ST_W'(1);
    end
    if (ctrl == RUN) begin
      rd_addr = next_idx;
    end else begin
      rd_addr = ST_W'(0);
    end
    // A zero duration behaves as one cycle; store the last n_clks value.
    if (rd_dur == CNT_W'(0)) begin
      rd_last = CNT_W'(0);
    end else begin
      rd_last = rd_dur - CNT_W'(1);
    end
    at_last_cycle = (n_clks == cur_last);
    if (rep_cnt == {REP_W{1'b1}}) begin
      rep_inc = rep_cnt;
    end else begin
      rep_inc = rep_cnt + REP_W'(1);
    end
    run_complete = (reps_lat != REP_W'(0)) && (rep_inc == reps_lat);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl        <= IDLE;
      busy        <= 1'b0;
      state       <= ST_W'(0);
      n_clks      <= CNT_W'(0);
      pat_out     <= IDLE_PAT;
      state_entry <= 1'b0;
      rep_cnt     <= REP_W'(0);
      seq_done    <= 1'b0;
      cur_last    <= CNT_W'(0);
      reps_lat    <= REP_W'(0);
    end else begin
      state_entry <= 1'b0;
      seq_done    <= 1'b0;
      case (ctrl)
        IDLE: begin
          if (start && !abort) begin
            ctrl        <= RUN;
            busy        <= 1'b1;
            state       <= ST_W'(0);
            n_clks      <= CNT_W'(0);
            pat_out     <= rd_pat;
            cur_last    <= rd_last;
            state_entry <= 1'b1;
            rep_cnt     <= REP_W'(0);
            reps_lat    <= n_reps;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            ctrl    <= IDLE;
            busy    <= 1'b0;
            state   <= ST_W'(0);
            n_clks  <= CNT_W'(0);
            pat_out <= IDLE_PAT;
          end else if (at_last_cycle) begin
            n_clks <= CNT_W'(0);
            if (at_last_state && run_complete) begin
              ctrl     <= IDLE;
              busy     <= 1'b0;
              state    <= ST_W'(0);
              pat_out  <= IDLE_PAT;
              seq_done <= 1'b1;
              rep_cnt  <= rep_inc;
            end else begin
              if (at_last_state) begin
                rep_cnt <= rep_inc;
              end else begin
                rep_cnt <= rep_cnt;
              end
              state       <= next_idx;
              pat_out     <= rd_pat;
              cur_last    <= rd_last;
              state_entry <= 1'b1;
            end
          end else begin
            n_clks <= n_clks + CNT_W'(1);
          end
        end
        default: begin
          ctrl    <= IDLE;
          busy    <= 1'b0;
          state   <= ST_W'(0);
          n_clks  <= CNT_W'(0);
          pat_out <= IDLE_PAT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_timing_controller.sv
// Self-checking bench for seq_timing_controller with a 4-state table: expected
// per-cycle traces are expanded from the programmed table by plain loops.
module tb_seq_timing_controller;

  localparam int N  = 4;
  localparam int SW = 3;
  localparam int CW = 27;
  localparam int OW = 8;
  localparam int RW = 4;

  typedef struct packed {
    logic          busy;
    logic [SW-1:0] st;
    logic [CW-1:0] nc;
    logic [OW-1:0] pat;
    logic          entry;
    logic [RW-1:0] rep;
    logic          done;
  } obs_t;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [SW-1:0] cfg_addr;
  logic [CW-1:0] cfg_dur;
  logic [OW-1:0] cfg_pat;
  logic          start;
  logic          abort;
  logic [RW-1:0] n_reps;
  logic          busy;
  logic [SW-1:0] state;
  logic [CW-1:0] n_clks;
  logic [OW-1:0] pat_out;
  logic          state_entry;
  logic [RW-1:0] rep_cnt;
  logic          seq_done;

  int total;
  int bad;
  int m_dur [N];
  logic [OW-1:0] m_pat [N];
  obs_t exp_q [$];

  seq_timing_controller #(
    .N_STATES (N), .ST_W (SW), .CNT_W (CW), .OUT_W (OW), .REP_W (RW),
    .IDLE_PAT (8'h00)
  ) dut (
    .clk (clk), .rst (rst), .cfg_we (cfg_we), .cfg_addr (cfg_addr),
    .cfg_dur (cfg_dur), .cfg_pat (cfg_pat), .start (start), .abort (abort),
    .n_reps (n_reps), .busy (busy), .state (state), .n_clks (n_clks),
    .pat_out (pat_out), .state_entry (state_entry), .rep_cnt (rep_cnt),
    .seq_done (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.busy = busy; o.st = state; o.nc = n_clks; o.pat = pat_out;
    o.entry = state_entry; o.rep = rep_cnt; o.done = seq_done;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0b st=%0d nc=%0d pat=%h entry=%0b rep=%0d done=%0b",
                     o.busy, o.st, o.nc, o.pat, o.entry, o.rep, o.done);
  endfunction

  function automatic obs_t idle_obs(input int rep, input bit done);
    obs_t o;
    o = '0;
    o.rep = RW'(rep);
    o.done = done;
    return o;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < N; s++) begin
      m_dur[s] = 1;
      m_pat[s] = 8'h00;
    end
  endfunction

  // One full pass over the table as seen during repetition k.
  function automatic void build_period(input int k);
    for (int s = 0; s < N; s++) begin
      int d;
      d = (m_dur[s] == 0) ? 1 : m_dur[s];
      for (int c = 0; c < d; c++) begin
        obs_t e;
        e.busy = 1'b1; e.st = SW'(s); e.nc = CW'(c); e.pat = m_pat[s];
        e.entry = (c == 0); e.rep = RW'((k > 15) ? 15 : k); e.done = 1'b0;
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic void build_finite(input int reps);
    exp_q.delete();
    for (int k = 0; k < reps; k++) build_period(k);
    exp_q.push_back(idle_obs(reps, 1'b1));
    exp_q.push_back(idle_obs(reps, 1'b0));
  endfunction

  function automatic void build_continuous(input int periods);
    exp_q.delete();
    for (int k = 0; k < periods; k++) build_period(k);
  endfunction

  task automatic prog(input int addr, input int dur, input logic [OW-1:0] pat);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = SW'(addr); cfg_dur = CW'(dur); cfg_pat = pat;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < N) begin
      m_dur[addr] = dur;
      m_pat[addr] = pat;
    end
  endtask

  // Starts a run and walks exp_q cycle by cycle; optional abort, config write
  // and ignored start pulses are injected at the given trace indices.
  task automatic run_sequence(input string name, input int reps, input int abort_idx,
                              input int wr_idx, input int wr_addr, input int wr_dur,
                              input logic [OW-1:0] wr_pat, input bit extra_start);
    obs_t o;
    @(negedge clk);
    n_reps = RW'(reps); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = observe();
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL %s idx=%0d got {%s} expected {%s}", name, i, fmt(o), fmt(exp_q[i]));
      end
      cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
      if (i == wr_idx) begin
        cfg_we = 1'b1; cfg_addr = SW'(wr_addr); cfg_dur = CW'(wr_dur); cfg_pat = wr_pat;
      end
      if (extra_start && exp_q[i].busy && (i % 3 == 1)) start = 1'b1;
      if (i == abort_idx) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
        o = observe();
        total++;
        if (o !== idle_obs(exp_q[i].rep, 1'b0)) begin
          bad++;
          $display("FAIL %s_abort got {%s} expected {%s}", name, fmt(o),
                   fmt(idle_obs(exp_q[i].rep, 1'b0)));
        end
        break;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    o = observe();
    total++;
    if (o !== idle_obs(0, 1'b0)) begin
      bad++;
      $display("FAIL reset got {%s} expected {%s}", fmt(o), fmt(idle_obs(0, 1'b0)));
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_plan_table();
    prog(0, 3, 8'hA1);
    prog(1, 1, 8'hB2);
    prog(2, 0, 8'hC3);
    prog(3, 2, 8'hD4);
  endtask

  task automatic test_single_run();
    load_plan_table();
    build_finite(1);
    run_sequence("single_run", 1, -1, -1, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_continuous();
    build_continuous(3);
    run_sequence("continuous", 0, exp_q.size() - 1, -1, 0, 0, 8'h00, 1'b1);
  endtask

  task automatic test_abort();
    prog(2, 3, 8'hC3);
    // Second pass, second cycle of state 2: 9-cycle period plus offset 5.
    build_continuous(2);
    run_sequence("abort", 0, 14, -1, 0, 0, 8'h00, 1'b0);
    build_finite(1);
    run_sequence("restart", 1, -1, -1, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_cfg_write_active();
    prog(2, 0, 8'hC3);
    exp_q.delete();
    build_period(0);
    m_dur[1] = 5;
    build_period(1);
    build_period(2);
    run_sequence("cfg_active", 0, exp_q.size() - 1, 3, 1, 5, 8'hB2, 1'b0);
  endtask

  task automatic test_start_abort_same();
    obs_t o;
    int held;
    held = rep_cnt;
    @(negedge clk);
    n_reps = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    o = observe();
    total++;
    if (o !== idle_obs(held, 1'b0)) begin
      bad++;
      $display("FAIL start_abort got {%s} expected {%s}", fmt(o), fmt(idle_obs(held, 1'b0)));
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    o = observe();
    total++;
    if (o !== idle_obs(held, 1'b0)) begin
      bad++;
      $display("FAIL abort_idle got {%s} expected {%s}", fmt(o), fmt(idle_obs(held, 1'b0)));
    end
  endtask

  task automatic test_saturate();
    prog(0, 1, 8'h11);
    prog(1, 0, 8'h22);
    prog(2, 1, 8'h33);
    prog(3, 0, 8'h44);
    build_continuous(18);
    run_sequence("saturate", 0, exp_q.size() - 1, -1, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    load_plan_table();
    prog(2, 3, 8'hC3);
    build_continuous(1);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    run_sequence("pre_reset", 0, -1, -1, 0, 0, 8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = observe();
    total++;
    if (o !== idle_obs(0, 1'b0)) begin
      bad++;
      $display("FAIL reset_midrun got {%s} expected {%s}", fmt(o), fmt(idle_obs(0, 1'b0)));
    end
    model_reset();
    build_finite(1);
    run_sequence("table_after_reset", 1, -1, -1, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int reps;
      for (int s = 0; s < N; s++) begin
        prog(s, $urandom_range(0, 4), OW'($urandom));
      end
      prog($urandom_range(N, 7), $urandom_range(0, 6), OW'($urandom));
      reps = $urandom_range(0, 3);
      if (reps == 0) begin
        build_continuous(2);
        run_sequence("random_cont", 0, $urandom_range(0, exp_q.size() - 1),
                     -1, 0, 0, 8'h00, 1'b1);
      end else begin
        build_finite(reps);
        run_sequence("random_fin", reps, -1, -1, 0, 0, 8'h00, 1'b1);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_dur = '0; cfg_pat = '0;
    start = 1'b0; abort = 1'b0; n_reps = '0;
    model_reset();
    test_reset();
    test_single_run();
    test_continuous();
    test_abort();
    test_cfg_write_active();
    test_start_abort_same();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
